// File: rtl/irq_arbiter.sv
// Round-robin-free priority scanner: walks all 32 interrupt sources, presents the best to the CPU, clears on ack.
// Define IRQ_ARB_NMI_EN to give sources 0-2 non-maskable priority; otherwise they are never selected.
module irq_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] irq_pending,
    input  logic [31:0] irq_enabled,
    input  logic [17:0] group_priority,
    input  logic [1:0]  cpu_i01,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [4:0]  irq_vector,
    output logic [3:0]  cpu_irq,
    output logic        irq_clear,
    output logic [4:0]  irq_clear_idx
);

    localparam logic [1:0] SCAN  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    best_idx_q, best_idx_d;
    logic [2:0]    best_pri_q, best_pri_d;
    logic [4:0]    vec_q, vec_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [3:0] cur_grp;
    logic [2:0] cur_pri;
    logic [4:0] fin_idx;
    logic [2:0] fin_pri;
    logic       withdraw;
    logic       timeout;

    function automatic logic [3:0] group_of(input logic [4:0] src);
        logic [3:0] g;
        g = 4'd0;
        case (src) inside
            [5'd3:5'd4]:   g = 4'd3;
            [5'd5:5'd6]:   g = 4'd2;
            [5'd7:5'd8]:   g = 4'd1;
            [5'd9:5'd10]:  g = 4'd0;
            [5'd11:5'd14]: g = 4'd7;
            [5'd15:5'd18]: g = 4'd8;
            [5'd19:5'd20]: g = 4'd6;
            [5'd21:5'd28]: g = 4'd5;
            [5'd29:5'd31]: g = 4'd4;
            default:       g = 4'd0;
        endcase
        return g;
    endfunction

    always_comb begin
        cur_grp = group_of(idx_q);
        cur_pri = '0;
        if (idx_q <= 5'd2) begin
`ifdef IRQ_ARB_NMI_EN
            if (irq_pending[idx_q]) cur_pri = 3'd4;
`endif
        end else if (irq_pending[idx_q] && irq_enabled[idx_q]) begin
            cur_pri = {1'b0, group_priority[{cur_grp, 1'b0} +: 2]};
        end
        // Strictly-greater replacement keeps the lowest index on ties.
        if (cur_pri > best_pri_q) begin
            fin_idx = idx_q;
            fin_pri = cur_pri;
        end else begin
            fin_idx = best_idx_q;
            fin_pri = best_pri_q;
        end
    end

    assign withdraw = !irq_pending[vec_q] || (!irq_enabled[vec_q] && (vec_q > 5'd2));
    assign timeout  = (ACK_TIMEOUT != 0) && (tcnt_q == TLAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_pri_d = best_pri_q;
        vec_d      = vec_q;
        lvl_d      = lvl_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            SCAN: begin
                idx_d      = idx_q + 5'd1;
                best_idx_d = fin_idx;
                best_pri_d = fin_pri;
                if (idx_q == 5'd31) begin
                    best_idx_d = '0;
                    best_pri_d = '0;
                    if (fin_pri > {1'b0, cpu_i01}) begin
                        state_d = REQ;
                        vec_d   = fin_idx;
                        lvl_d   = fin_pri;
                        tcnt_d  = '0;
                    end
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = CLEAR;
                end else if (withdraw || timeout) begin
                    state_d = SCAN;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            CLEAR: state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SCAN;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_pri_q <= '0;
            vec_q      <= '0;
            lvl_q      <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_pri_q <= best_pri_d;
            vec_q      <= vec_d;
            lvl_q      <= lvl_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Outputs decode straight from state so an async reset zeroes them at once.
    always_comb begin
        irq_req       = (state_q == REQ);
        irq_clear     = (state_q == CLEAR);
        irq_vector    = irq_req ? vec_q : '0;
        irq_clear_idx = irq_clear ? vec_q : '0;
        cpu_irq       = '0;
        if (irq_req) begin
            case (lvl_q)
                3'd1: cpu_irq = 4'b0001;
                3'd2: cpu_irq = 4'b0010;
                3'd3: cpu_irq = 4'b0100;
`ifdef IRQ_ARB_NMI_EN
                3'd4: cpu_irq = 4'b1000;
`endif
                default: cpu_irq = '0;
            endcase
        end
    end

endmodule
